// File: rtl/data_receive.sv
// data_receive
//   Read-direction DAT0 receiver for the SD host data path. Hunts for the
//   start bit and deserializes the block payload MSB-first into FIFO words.
//   It then checks the trailing CRC16-CCITT and the end bit, and reports the
//   block status to data_control.
//
//   Optional macro: DATA_RX_STATS_EN adds oCrc_err_count, a saturating count
//   of blocks that finished with a CRC error. Only reset clears it.
//
// Ports:
//   iClock, iReset       clock (rising edge) / async active-low reset
//   iEnable              1 = receive one block, 0 = abort / idle
//   iSample_en           one-cycle strobe per SD clock; DAT sampled on it
//   iData_pin            synchronized DAT0
//   iTimeout_reg         start-bit timeout in strobes (0 = no timeout)
//   iFIFO_full           FIFO full flag
//   oData_to_FIFO        assembled word
//   oWrite_enable        one-cycle FIFO push
//   oBusy                state != IDLE
//   oBlock_done          one-cycle pulse at block end
//   oCrc_error, oEnd_error, oTimeout, oOverflow   sticky status flags
module data_receive #(
    parameter int FIFO_data_size = 32,
    parameter int Block_bytes    = 512,
    parameter int Register_size  = 16
) (
    input  logic                      iClock,
    input  logic                      iReset,
    input  logic                      iEnable,
    input  logic                      iSample_en,
    input  logic                      iData_pin,
    input  logic [Register_size-1:0]  iTimeout_reg,
    input  logic                      iFIFO_full,
    output logic [FIFO_data_size-1:0] oData_to_FIFO,
    output logic                      oWrite_enable,
    output logic                      oBusy,
    output logic                      oBlock_done,
    output logic                      oCrc_error,
    output logic                      oEnd_error,
    output logic                      oTimeout,
    output logic                      oOverflow
`ifdef DATA_RX_STATS_EN
    ,
    output logic [15:0]               oCrc_err_count
`endif
);

    localparam int BLOCK_BITS = Block_bytes * 8;
    localparam int CNT_W      = $clog2(BLOCK_BITS + 1);
    localparam int WC_W       = $clog2(FIFO_data_size);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END, S_DONE
    } state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          bit_cnt;   // payload bits in DATA, CRC bits in CRC
    logic [WC_W-1:0]           word_cnt;  // bit position inside the current word
    logic [Register_size-1:0]  tmo_cnt;
    logic [Register_size-1:0]  tmo_nxt;
    logic [FIFO_data_size-1:0] shift;
    logic [FIFO_data_size-1:0] word_nxt;
    logic [15:0]               crc;
    logic [15:0]               crc_nxt;
    logic [15:0]               rx_crc;
    logic [15:0]               rx_crc_nxt;
    logic                      strobe;
    logic                      timeout_hit;
    logic                      data_last;
    logic                      crc_last;
    logic                      word_last;

    assign strobe      = iEnable && iSample_en;
    assign tmo_nxt     = tmo_cnt + 1'b1;
    assign timeout_hit = (iTimeout_reg != '0) && (tmo_nxt == iTimeout_reg);
    assign data_last   = (bit_cnt == CNT_W'(BLOCK_BITS - 1));
    assign crc_last    = (bit_cnt == CNT_W'(15));
    assign word_last   = (word_cnt == WC_W'(FIFO_data_size - 1));
    assign word_nxt    = {shift[FIFO_data_size-2:0], iData_pin};
    assign rx_crc_nxt  = {rx_crc[14:0], iData_pin};
    // CRC16-CCITT (0x1021), MSB-first, one bit per strobe
    assign crc_nxt     = {crc[14:0], 1'b0} ^ ((crc[15] ^ iData_pin) ? 16'h1021 : 16'h0000);

    // State register
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next state: strobe-gated except abort and DONE -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (strobe) state_nxt = S_WAIT_START;
            S_WAIT_START: if (!iEnable) state_nxt = S_IDLE;
                          else if (iSample_en) begin
                              if (!iData_pin)       state_nxt = S_DATA;
                              else if (timeout_hit) state_nxt = S_DONE;
                          end
            S_DATA:       if (!iEnable) state_nxt = S_IDLE;
                          else if (iSample_en && data_last) state_nxt = S_CRC;
            S_CRC:        if (!iEnable) state_nxt = S_IDLE;
                          else if (iSample_en && crc_last) state_nxt = S_END;
            S_END:        if (!iEnable) state_nxt = S_IDLE;
                          else if (iSample_en) state_nxt = S_DONE;
            S_DONE:       state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        oBusy       = (state != S_IDLE);
        oBlock_done = (state == S_DONE);
    end

    // Datapath. Every update is qualified by strobe (iEnable high), so an
    // abort cycle never completes or pushes a partial word.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            bit_cnt       <= '0;
            word_cnt      <= '0;
            tmo_cnt       <= '0;
            shift         <= '0;
            crc           <= '0;
            rx_crc        <= '0;
            oData_to_FIFO <= '0;
            oWrite_enable <= 1'b0;
            oCrc_error    <= 1'b0;
            oEnd_error    <= 1'b0;
            oTimeout      <= 1'b0;
            oOverflow     <= 1'b0;
        end else begin
            oWrite_enable <= 1'b0;
            case (state)
                S_IDLE: if (strobe) begin
                    bit_cnt    <= '0;
                    word_cnt   <= '0;
                    tmo_cnt    <= '0;
                    crc        <= '0;
                    oCrc_error <= 1'b0;
                    oEnd_error <= 1'b0;
                    oTimeout   <= 1'b0;
                    oOverflow  <= 1'b0;
                end
                S_WAIT_START: if (strobe && iData_pin) begin
                    tmo_cnt <= tmo_nxt;
                    if (timeout_hit) oTimeout <= 1'b1;
                end
                S_DATA: if (strobe) begin
                    shift    <= word_nxt;
                    crc      <= crc_nxt;
                    bit_cnt  <= data_last ? '0 : bit_cnt + 1'b1;
                    word_cnt <= word_last ? '0 : word_cnt + 1'b1;
                    if (word_last) begin
                        // A full FIFO drops the word but reception carries on
                        if (iFIFO_full) begin
                            oOverflow <= 1'b1;
                        end else begin
                            oData_to_FIFO <= word_nxt;
                            oWrite_enable <= 1'b1;
                        end
                    end
                end
                S_CRC: if (strobe) begin
                    rx_crc  <= rx_crc_nxt;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (crc_last && (rx_crc_nxt != crc)) oCrc_error <= 1'b1;
                end
                S_END: if (strobe && !iData_pin) oEnd_error <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef DATA_RX_STATS_EN
    // Saturating count of blocks that ended with a CRC error
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset)
            oCrc_err_count <= '0;
        else if (state == S_DONE && oCrc_error && oCrc_err_count != 16'hFFFF)
            oCrc_err_count <= oCrc_err_count + 16'd1;
    end
`else
    // Statistics disabled: no counter
`endif

endmodule

// File: doc/data_receive.md
Name: data_receive

Overview:
- Read-direction DAT-line receiver for the SD host data path.
- Sits between the SD card DAT0 pin and the asynchronous FIFO write side. It hunts for the start bit, deserializes block payload MSB-first into 32-bit words, and pushes each word into the FIFO.
- Checks the trailing CRC16 and end bit, then reports block completion, CRC error, end-bit error, start timeout and overflow to data_control.

Parameters:
FIFO_data_size, 32, width of a FIFO word; must be a multiple of 8.
Block_bytes, 512, payload bytes per block; must be a multiple of FIFO_data_size/8.
Register_size, 16, width of the timeout register.

Ports:
iClock  input  1  system clock; all logic on rising edge.
iReset  input  1  asynchronous, active-low reset.
iEnable  input  1  level from data_control: 1 = receive one block; 0 = abort or idle.
iSample_en  input  1  one-cycle strobe per SD clock period; DAT is sampled only on the strobe.
iData_pin  input  1  DAT0 line from the card, already synchronized.
iTimeout_reg  input  Register_size  start-bit timeout, in sample strobes; 0 disables the timeout.
iFIFO_full  input  1  FIFO full flag.
oData_to_FIFO  output  FIFO_data_size  assembled word.
oWrite_enable  output  1  one-cycle FIFO push strobe.
oBusy  output  1  high in any state except IDLE.
oBlock_done  output  1  one-cycle pulse when the block has finished, with or without errors.
oCrc_error  output  1  sticky: received CRC differs from computed CRC.
oEnd_error  output  1  sticky: end bit sampled as 0.
oTimeout  output  1  sticky: no start bit arrived within iTimeout_reg strobes.
oOverflow  output  1  sticky: a word completed while iFIFO_full=1.

Behaviour:
- Reset (iReset=0, asynchronous): state IDLE; every output, counter, shift register and CRC register is cleared to 0.
- FSM states: IDLE, WAIT_START, DATA, CRC, END, DONE. State updates occur only on iSample_en=1, except the abort and DONE->IDLE transitions.
- IDLE -> WAIT_START on iEnable=1. Entering WAIT_START clears all sticky flags, the CRC register (to 0x0000), the bit counter and the timeout counter.
- WAIT_START:
  - Sample DAT=0: this is the start bit; go to DATA.
  - Otherwise increment the timeout counter. If iTimeout_reg!=0 and the counter reaches iTimeout_reg, set oTimeout and go to DONE.
- DATA:
  - Each strobe shifts the DAT bit into the word LSB side, so the first bit received becomes the word MSB.
  - CRC16-CCITT update, polynomial x^16+x^12+x^5+1, initial value 0, MSB-first.
  - After every FIFO_data_size bits, oData_to_FIFO is loaded and oWrite_enable pulses on the next iClock cycle.
  - If iFIFO_full=1 at that push, the word is dropped (no strobe) and oOverflow is set; reception continues.
  - After Block_bytes*8 bits, go to CRC.
- CRC: shift 16 bits MSB-first into the received-CRC register. After 16 bits, compare against the computed CRC; on mismatch set oCrc_error. Go to END.
- END: sample the end bit; if it is 0, set oEnd_error. Go to DONE.
- DONE: pulse oBlock_done for one iClock cycle, then go to IDLE.
  - Re-arming requires iEnable to be 0 for at least one cycle before the next block, or iEnable held at 1 after DONE.
  - Holding iEnable=1 re-enters WAIT_START on the following cycle, which supports multi-block reads.
- Abort: iEnable=0 in any state other than IDLE or DONE returns to IDLE on the next iClock edge. No oBlock_done pulse is produced. Sticky flags are held. A partial word is not pushed.
- Latency: the FIFO push occurs 1 iClock cycle after the strobe that samples the word's final bit.
- oBusy is purely state-decoded.

Optional Feature:
- Macro: DATA_RX_STATS_EN.
- Defined:
  - Adds output oCrc_err_count [15:0].
  - The counter increments once per block that ends with oCrc_error=1, and saturates at 0xFFFF.
  - It is cleared only by reset; an abort does not clear it.
- Not defined: no port and no counter logic; all other behaviour is unchanged.

Test Plan:
- Clean block: 512 bytes of 0xFF framed with start bit 0, CRC 0x7FA1 and end bit 1 -> 128 pushes of 0xFFFFFFFF, oBlock_done pulse, all error flags 0.
- Bad CRC: the same block with CRC 0x7FA0 -> 128 pushes, oCrc_error=1, oBlock_done pulse; with DATA_RX_STATS_EN defined, oCrc_err_count=1.
- Start timeout: iTimeout_reg=20 and DAT held at 1 -> oTimeout=1 after the 20th strobe, oBlock_done pulse, no pushes.
- FIFO full: iFIFO_full=1 during word 5 (payload bytes 0x00,0x01,...) -> word 5 not written, oOverflow=1; the other 127 words are correct, e.g. word 0 = 0x00010203.
- Abort and reset: drop iEnable after 100 payload bits -> oBusy=0 on the next cycle, no oBlock_done, 3 pushes total. Separately, pulse iReset=0 mid-DATA -> all outputs 0 immediately, without waiting for a clock edge.
- Bad end bit plus multi-block: end bit 0 on block 1 with iEnable held at 1 -> oEnd_error=1 and oBlock_done pulse; a clean block 2 then clears oEnd_error on entry to WAIT_START and completes with no errors.
